// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request FSM and IF/ID pipeline register.
// Optional delivered-instruction counter is enabled by IF_STAGE_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch,
  input  logic [27:0] offset28,
  input  logic [31:0] rs,
  input  logic        if_flush,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_4_out,
  output logic [31:0] ins_out,
  output logic        ins_valid,
  output logic [31:0] fetch_cnt,
  output logic [1:0]  state_dbg
);

  // imem handshake: a request is held with a stable address while imem_req=1
  // and imem_ack=0; exactly one imem_ack (with imem_rdata) answers each request.
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DROP = 2'd3} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic [31:0] drop_addr;
  logic [31:0] hold_buf;
  logic [31:0] target;
  logic        redirect;
  logic        deliver;
  logic        bubble;
  logic [31:0] deliver_data;

  assign pc_4      = pc + 32'd4;
  assign redirect  = (pc_src != 2'b00) && !stall;
  assign imem_req  = (state == FETCH) || (state == DROP);
  assign imem_addr = (state == DROP) ? drop_addr : pc;
  assign state_dbg = state;

  always_comb begin
    target = rs;
    case (pc_src)
      2'b01:   target = branch;
      2'b10:   target = {pc_4_out[31:28], offset28};
      default: target = rs;
    endcase
  end

  // Decide what the IF/ID register takes this cycle; flush wins over everything.
  always_comb begin
    deliver      = 1'b0;
    bubble       = 1'b0;
    deliver_data = imem_rdata;
    case (state)
      FETCH: if (!stall) begin
        if (imem_ack && !redirect) deliver = 1'b1;
        else                       bubble  = 1'b1;
      end
      HOLD: begin
        deliver_data = hold_buf;
        if (!stall) begin
          if (redirect) bubble  = 1'b1;
          else          deliver = 1'b1;
        end
      end
      DROP:    if (!stall) bubble = 1'b1;
      default: ;
    endcase
    if (if_flush) begin
      deliver = 1'b0;
      bubble  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop_addr <= 32'd0;
      hold_buf  <= 32'd0;
      pc_4_out  <= 32'd0;
      ins_out   <= 32'd0;
      ins_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (redirect) begin
            pc <= target;
            if (!imem_ack) begin
              drop_addr <= pc;
              state     <= DROP;
            end
          end else if (imem_ack && stall) begin
            hold_buf <= imem_rdata;
            state    <= HOLD;
          end else if (imem_ack) begin
            pc <= pc_4;
          end
        end
        HOLD: begin
          if (redirect || if_flush) begin
            pc       <= redirect ? target : pc_4;
            hold_buf <= 32'd0;
            state    <= FETCH;
          end else if (!stall) begin
            pc    <= pc_4;
            state <= FETCH;
          end
        end
        DROP: begin
          // The response to drop_addr is stale; swallow it, keep the new pc.
          if (redirect) pc <= target;
          if (imem_ack) state <= FETCH;
        end
        default: state <= IDLE;
      endcase

      if (bubble) begin
        pc_4_out  <= 32'd0;
        ins_out   <= 32'd0;
        ins_valid <= 1'b0;
      end else if (deliver) begin
        pc_4_out  <= pc_4;
        ins_out   <= deliver_data;
        ins_valid <= 1'b1;
      end
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= 32'd0;
    else if (deliver) cnt <= cnt + 32'd1;
  end
  assign fetch_cnt = cnt;
`else
  assign fetch_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming fetch, stall/hold, redirects,
// stale-response drop, PC wrap, reset abandonment and the optional counter.
module tb_if_stage;
  localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2, S_DROP = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] branch = 32'd0;
  logic [27:0] offset28 = 28'd0;
  logic [31:0] rs = 32'd0;
  logic        if_flush = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_4_out;
  logic [31:0] ins_out;
  logic        ins_valid;
  logic [31:0] fetch_cnt;
  logic [1:0]  state_dbg;

  // Memory model: zero-wait echo of the address, or manually driven response.
  logic        mem_auto = 1'b1;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'd0;
  assign imem_ack   = mem_auto ? imem_req  : man_ack;
  assign imem_rdata = mem_auto ? imem_addr : man_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .branch(branch), .offset28(offset28),
    .rs(rs), .if_flush(if_flush), .stall(stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_4_out(pc_4_out), .ins_out(ins_out), .ins_valid(ins_valid),
    .fetch_cnt(fetch_cnt), .state_dbg(state_dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    tests_run++;
    if ({state_dbg, imem_req, ins_valid} !== {S_IDLE, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: got st=%0d req=%0b v=%0b expected st=0 req=0 v=0", state_dbg, imem_req, ins_valid);
    end
    tests_run++;
    if ({pc_4_out, ins_out, fetch_cnt} !== 96'd0) begin
      tests_failed++;
      $display("FAIL reset_regs: got pc4=%h ins=%h cnt=%h expected all 0", pc_4_out, ins_out, fetch_cnt);
    end
    reset = 1'b0;
    tests_run++;
    if (imem_req !== 1'b0 || state_dbg !== S_IDLE) begin
      tests_failed++;
      $display("FAIL idle_after_release: got st=%0d req=%0b expected st=0 req=0", state_dbg, imem_req);
    end
  endtask

  task automatic test_stream();
    step();
    tests_run++;
    if ({state_dbg, imem_req, imem_addr, ins_valid} !== {S_FETCH, 1'b1, 32'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL first_fetch: got st=%0d req=%0b addr=%h v=%0b expected st=1 req=1 addr=0 v=0", state_dbg, imem_req, imem_addr, ins_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if ({ins_out, pc_4_out, ins_valid} !== {32'(4 * i), 32'(4 * i + 4), 1'b1}) begin
        tests_failed++;
        $display("FAIL stream_%0d: got ins=%h pc4=%h v=%0b expected ins=%h pc4=%h v=1", i, ins_out, pc_4_out, ins_valid, 4 * i, 4 * i + 4);
      end
    end
  endtask

  task automatic test_stall_hold();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if ({state_dbg, imem_req, ins_out, pc_4_out} !== {S_HOLD, 1'b0, 32'd12, 32'd16}) begin
        tests_failed++;
        $display("FAIL stall_%0d: got st=%0d req=%0b ins=%h pc4=%h expected st=2 req=0 ins=c pc4=10", i, state_dbg, imem_req, ins_out, pc_4_out);
      end
    end
    stall = 1'b0;
    step();
    tests_run++;
    if ({state_dbg, ins_out, pc_4_out, ins_valid} !== {S_FETCH, 32'd16, 32'd20, 1'b1}) begin
      tests_failed++;
      $display("FAIL hold_release: got st=%0d ins=%h pc4=%h v=%0b expected st=1 ins=10 pc4=14 v=1", state_dbg, ins_out, pc_4_out, ins_valid);
    end
    step();
    tests_run++;
    if ({ins_out, pc_4_out} !== {32'd20, 32'd24}) begin
      tests_failed++;
      $display("FAIL after_hold: got ins=%h pc4=%h expected ins=14 pc4=18", ins_out, pc_4_out);
    end
  endtask

  task automatic test_branch_flush();
    pc_src = 2'b01;
    branch = 32'h0000_0100;
    if_flush = 1'b1;
    step();
    pc_src = 2'b00;
    if_flush = 1'b0;
    tests_run++;
    if ({ins_valid, ins_out, pc_4_out, imem_addr} !== {1'b0, 32'd0, 32'd0, 32'h100}) begin
      tests_failed++;
      $display("FAIL branch_flush: got v=%0b ins=%h pc4=%h addr=%h expected v=0 ins=0 pc4=0 addr=100", ins_valid, ins_out, pc_4_out, imem_addr);
    end
    step();
    tests_run++;
    if ({ins_out, pc_4_out, ins_valid} !== {32'h100, 32'h104, 1'b1}) begin
      tests_failed++;
      $display("FAIL branch_target: got ins=%h pc4=%h v=%0b expected ins=100 pc4=104 v=1", ins_out, pc_4_out, ins_valid);
    end
  endtask

  task automatic test_jr_drop();
    mem_auto = 1'b0;
    man_ack = 1'b0;
    pc_src = 2'b11;
    rs = 32'h0000_0040;
    step();
    pc_src = 2'b00;
    tests_run++;
    if ({state_dbg, imem_req, imem_addr, ins_valid} !== {S_DROP, 1'b1, 32'h104, 1'b0}) begin
      tests_failed++;
      $display("FAIL jr_drop: got st=%0d req=%0b addr=%h v=%0b expected st=3 req=1 addr=104 v=0", state_dbg, imem_req, imem_addr, ins_valid);
    end
    step();
    tests_run++;
    if ({state_dbg, imem_addr} !== {S_DROP, 32'h104}) begin
      tests_failed++;
      $display("FAIL drop_stable: got st=%0d addr=%h expected st=3 addr=104", state_dbg, imem_addr);
    end
    man_ack = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    step();
    man_ack = 1'b0;
    tests_run++;
    if ({state_dbg, imem_addr, ins_valid} !== {S_FETCH, 32'h40, 1'b0}) begin
      tests_failed++;
      $display("FAIL drop_discard: got st=%0d addr=%h v=%0b expected st=1 addr=40 v=0", state_dbg, imem_addr, ins_valid);
    end
    mem_auto = 1'b1;
    step();
    tests_run++;
    if ({ins_out, pc_4_out, ins_valid} !== {32'h40, 32'h44, 1'b1}) begin
      tests_failed++;
      $display("FAIL jr_target: got ins=%h pc4=%h v=%0b expected ins=40 pc4=44 v=1", ins_out, pc_4_out, ins_valid);
    end
  endtask

  task automatic test_jump();
    pc_src = 2'b01;
    branch = 32'h4000_000C;
    step();
    pc_src = 2'b00;
    step();
    tests_run++;
    if (pc_4_out !== 32'h4000_0010) begin
      tests_failed++;
      $display("FAIL jump_setup: got pc4=%h expected pc4=40000010", pc_4_out);
    end
    pc_src = 2'b10;
    offset28 = 28'h000_0080;
    step();
    pc_src = 2'b00;
    tests_run++;
    if (imem_addr !== 32'h4000_0080) begin
      tests_failed++;
      $display("FAIL jump_target: got addr=%h expected addr=40000080", imem_addr);
    end
  endtask

  task automatic test_wrap();
    pc_src = 2'b01;
    branch = 32'hFFFF_FFFC;
    step();
    pc_src = 2'b00;
    step();
    tests_run++;
    if ({ins_out, pc_4_out, imem_addr} !== {32'hFFFF_FFFC, 32'd0, 32'd0}) begin
      tests_failed++;
      $display("FAIL pc_wrap: got ins=%h pc4=%h addr=%h expected ins=fffffffc pc4=0 addr=0", ins_out, pc_4_out, imem_addr);
    end
  endtask

  task automatic test_reset_abandon_and_count();
    logic [31:0] exp_cnt;
    mem_auto = 1'b0;
    man_ack = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1;
    tests_run++;
    if ({state_dbg, imem_req} !== {S_IDLE, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid_req: got st=%0d req=%0b expected st=0 req=0", state_dbg, imem_req);
    end
    man_ack = 1'b1;
    man_rdata = 32'h1234_5678;
    step();
    reset = 1'b0;
    step();
    man_ack = 1'b0;
    tests_run++;
    if ({state_dbg, ins_valid, imem_addr} !== {S_FETCH, 1'b0, 32'd0}) begin
      tests_failed++;
      $display("FAIL late_ack_ignored: got st=%0d v=%0b addr=%h expected st=1 v=0 addr=0", state_dbg, ins_valid, imem_addr);
    end
    mem_auto = 1'b1;
    for (int i = 0; i < 10; i++) step();
    tests_run++;
    if ({ins_out, ins_valid} !== {32'd36, 1'b1}) begin
      tests_failed++;
      $display("FAIL ten_delivered: got ins=%h v=%0b expected ins=24 v=1", ins_out, ins_valid);
    end
    if_flush = 1'b1;
    step();
    step();
    if_flush = 1'b0;
    stall = 1'b1;
    tests_run++;
    if (ins_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flushed_bubble: got v=%0b expected v=0", ins_valid);
    end
`ifdef IF_STAGE_PERF_CNT_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    tests_run++;
    if (fetch_cnt !== exp_cnt) begin
      tests_failed++;
      $display("FAIL fetch_cnt: got %0d expected %0d", fetch_cnt, exp_cnt);
    end
    stall = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_stream();
    test_stall_hold();
    test_branch_flush();
    test_jr_drop();
    test_jump();
    test_wrap();
    test_reset_abandon_and_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
